// File: rtl/seconds_minutes_counter.sv
// -----------------------------------------------------------------------------
// seconds_minutes_counter
//
// Purpose:
//   MM:SS time counter in BCD. It counts up or down once per rising edge of a
//   slow 1 Hz square wave. That wave is treated as asynchronous data and is
//   never used as a clock. It passes through a two-flop synchronizer and an
//   edge detector. The detector is "armed" only after a real low level has
//   been sampled, so a clk_1Hz that is already high when reset is released
//   is not counted as an edge.
//
// Parameters:
//   MAX_MIN   highest minutes value before wrap (1..59)
//
// Ports:
//   clk       in   system clock (50 MHz), the only clock
//   reset     in   synchronous active-high reset
//   clk_1Hz   in   slow square wave, sampled as data
//   run       in   counting enabled while high
//   clear     in   synchronous clear of the time to 00:00
//   down      in   0 = count up, 1 = count down
//   sec_ones  out  seconds ones digit, BCD 0..9
//   sec_tens  out  seconds tens digit, 0..5
//   min_ones  out  minutes ones digit, BCD 0..9
//   min_tens  out  minutes tens digit, 0..5
//   tick      out  one-cycle pulse per accepted clk_1Hz rising edge
//   rollover  out  one-cycle pulse when the count wraps
// -----------------------------------------------------------------------------
module seconds_minutes_counter #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       run,
    input  logic       clear,
    input  logic       down,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       tick,
    output logic       rollover
);

    localparam logic [2:0] MAX_TENS = 3'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    // ------------------------------------------------------------------
    // Synchronizer, history flop and edge detector
    // ------------------------------------------------------------------
    logic       s1_q, s2_q, s3_q;
    logic       armed_q, armed_d;
    logic [1:0] fill_q;          // fill_q[1] set: s2 holds a real sample
    logic       tick_q, tick_d;

    // The reset value of s2 (0) is not a real observation of clk_1Hz.
    // Arming waits until a genuinely sampled low has reached s2.
    // Otherwise a wave held high through reset release would look like
    // a fresh edge.
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~s2_q);
        tick_d  = s2_q & ~s3_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= clk_1Hz;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
            tick_q  <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // BCD time registers
    // ------------------------------------------------------------------
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [2:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [2:0] min_tens_q, min_tens_d;
    logic       roll_q, roll_d;

    logic       min_at_max;
    logic       min_at_zero;

    // Relational compares let an out-of-range minutes value fall back
    // into the legal range on the next update.
    assign min_at_max  = (min_tens_q > MAX_TENS) ||
                         ((min_tens_q == MAX_TENS) && (min_ones_q >= MAX_ONES));
    assign min_at_zero = (min_tens_q == 3'd0) && (min_ones_q == 4'd0);

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        roll_d     = 1'b0;

        if (clear) begin
            // Clear wins over a tick in the same cycle.
            sec_ones_d = 4'd0;
            sec_tens_d = 3'd0;
            min_ones_d = 4'd0;
            min_tens_d = 3'd0;
        end else if (tick_q && run) begin
            if (!down) begin
                // Up count.
                // Each digit wraps at its top value and carries into the next digit.
                if (sec_ones_q < 4'd9) begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end else begin
                    sec_ones_d = 4'd0;
                    if (sec_tens_q < 3'd5) begin
                        sec_tens_d = sec_tens_q + 3'd1;
                    end else begin
                        sec_tens_d = 3'd0;
                        if (min_at_max) begin
                            min_ones_d = 4'd0;
                            min_tens_d = 3'd0;
                            roll_d     = 1'b1;
                        end else if (min_ones_q < 4'd9) begin
                            min_ones_d = min_ones_q + 4'd1;
                        end else begin
                            min_ones_d = 4'd0;
                            min_tens_d = min_tens_q + 3'd1;
                        end
                    end
                end
            end else begin
                // Down count.
                // A digit at zero borrows from the next digit and reloads its top value.
                // Any out-of-range digit is clamped to its top value.
                if (sec_ones_q > 4'd9) begin
                    sec_ones_d = 4'd9;
                end else if (sec_ones_q != 4'd0) begin
                    sec_ones_d = sec_ones_q - 4'd1;
                end else begin
                    sec_ones_d = 4'd9;
                    if (sec_tens_q > 3'd5) begin
                        sec_tens_d = 3'd5;
                    end else if (sec_tens_q != 3'd0) begin
                        sec_tens_d = sec_tens_q - 3'd1;
                    end else begin
                        sec_tens_d = 3'd5;
                        if (min_at_zero) begin
                            min_ones_d = MAX_ONES;
                            min_tens_d = MAX_TENS;
                            roll_d     = 1'b1;
                        end else if (min_at_max) begin
                            // Covers both MAX_MIN itself and out-of-range values.
                            // In either case, step down by one minute from MAX_MIN.
                            min_ones_d = (MAX_ONES == 4'd0) ? 4'd9 : MAX_ONES - 4'd1;
                            min_tens_d = (MAX_ONES == 4'd0) ? MAX_TENS - 3'd1 : MAX_TENS;
                        end else if (min_ones_q > 4'd9) begin
                            min_ones_d = 4'd9;
                        end else if (min_ones_q != 4'd0) begin
                            min_ones_d = min_ones_q - 4'd1;
                        end else begin
                            min_ones_d = 4'd9;
                            min_tens_d = min_tens_q - 3'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 3'd0;
            roll_q     <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            roll_q     <= roll_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign tick     = tick_q;
    assign rollover = roll_q;

endmodule

// File: tb/tb_seconds_minutes_counter.sv
// -----------------------------------------------------------------------------
// tb_seconds_minutes_counter
//
// Drives two counters with the same stimulus:
//   u_a uses the default MAX_MIN of 59.
//   u_b uses MAX_MIN = 9.
// Each counter is compared against an elapsed-seconds reference model.
// -----------------------------------------------------------------------------
module tb_seconds_minutes_counter;

    logic       clk = 1'b0;
    logic       reset, clk_1Hz, run, clear, down;
    logic [3:0] a_so, a_mo, b_so, b_mo;
    logic [2:0] a_st, a_mt, b_st, b_mt;
    logic       a_tick, a_roll, b_tick, b_roll;

    int checks = 0;
    int errors = 0;

    // Reference model: time held as total seconds, wrapping at a period.
    int ta = 0;
    int tb_t = 0;
    localparam int PER_A = 60 * 60;
    localparam int PER_B = 10 * 60;

    always #10 clk = ~clk;

    seconds_minutes_counter u_a (
        .clk(clk), .reset(reset), .clk_1Hz(clk_1Hz), .run(run), .clear(clear),
        .down(down), .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo),
        .min_tens(a_mt), .tick(a_tick), .rollover(a_roll)
    );

    seconds_minutes_counter #(.MAX_MIN(9)) u_b (
        .clk(clk), .reset(reset), .clk_1Hz(clk_1Hz), .run(run), .clear(clear),
        .down(down), .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo),
        .min_tens(b_mt), .tick(b_tick), .rollover(b_roll)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Displayed time as a decimal MMSS number.
    function automatic int disp_a();
        return int'(a_mt) * 1000 + int'(a_mo) * 100 + int'(a_st) * 10 + int'(a_so);
    endfunction
    function automatic int disp_b();
        return int'(b_mt) * 1000 + int'(b_mo) * 100 + int'(b_st) * 10 + int'(b_so);
    endfunction
    function automatic int mmss(input int t);
        return (t / 60) * 100 + (t % 60);
    endfunction

    // One accepted clk_1Hz edge, advancing the model with a wrap flag.
    task automatic model_step(input int period, input bit clr, inout int t, output bit roll);
        roll = 1'b0;
        if (clr) begin
            t = 0;
        end else if (run) begin
            if (!down) begin
                t = t + 1;
                if (t == period) begin
                    t = 0;
                    roll = 1'b1;
                end
            end else if (t == 0) begin
                t = period - 1;
                roll = 1'b1;
            end else begin
                t = t - 1;
            end
        end
    endtask

    // Full clk_1Hz period starting at a negedge.
    // The next posedge (k=0) is where s1 samples the new high level.
    // Tick must be seen only at k=2.
    // The digits and the rollover must update at k=3.
    task automatic one_tick(input bit verbose, input bit clr_at_tick);
        int hi, lo, first, cnt_a, cnt_b;
        bit ra, rb;
        hi = $urandom_range(5, 4);
        lo = $urandom_range(4, 3);
        first = -1; cnt_a = 0; cnt_b = 0;
        model_step(PER_A, clr_at_tick, ta, ra);
        model_step(PER_B, clr_at_tick, tb_t, rb);
        clk_1Hz = 1'b1;
        for (int k = 0; k < hi + lo; k++) begin
            @(negedge clk);
            if (a_tick) begin
                cnt_a++;
                if (first < 0) first = k;
            end
            if (b_tick) cnt_b++;
            if (k == 3) begin
                chk("disp_a", disp_a(), mmss(ta));
                chk("disp_b", disp_b(), mmss(tb_t));
                chk("roll_a", int'(a_roll), int'(ra));
                chk("roll_b", int'(b_roll), int'(rb));
            end else begin
                chk("roll_a_idle", int'(a_roll), 0);
                chk("roll_b_idle", int'(b_roll), 0);
            end
            if (k == hi - 1) clk_1Hz = 1'b0;
            if (k == 2 && clr_at_tick) clear = 1'b1;
            if (k == 3) clear = 1'b0;
        end
        chk("tick_cnt_a", cnt_a, 1);
        chk("tick_cnt_b", cnt_b, 1);
        chk("tick_pos", first, 2);
        if (verbose)
            $display("tick run=%0d down=%0d clr=%0d A=%04d B=%04d roll=%0d/%0d",
                     run, down, clr_at_tick, disp_a(), disp_b(), a_roll, b_roll);
    endtask

    // Idle cycles: no tick may appear, and the display must stay put.
    task automatic idle(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (a_tick || b_tick) cnt++;
        end
        chk({tag, "_ticks"}, cnt, 0);
        chk({tag, "_disp_a"}, disp_a(), mmss(ta));
        chk({tag, "_disp_b"}, disp_b(), mmss(tb_t));
        $display("idle %s cycles=%0d A=%04d B=%04d", tag, n, disp_a(), disp_b());
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ta = 0;
        tb_t = 0;
        chk("clear_a", disp_a(), 0);
        chk("clear_b", disp_b(), 0);
        $display("clear A=%04d B=%04d", disp_a(), disp_b());
    endtask

    task automatic do_reset(input bit level_1hz);
        @(negedge clk);
        reset = 1'b1;
        clk_1Hz = level_1hz;
        repeat (3) @(negedge clk);
        chk("rst_disp_a", disp_a(), 0);
        chk("rst_disp_b", disp_b(), 0);
        chk("rst_tick", int'(a_tick), 0);
        chk("rst_roll", int'(a_roll), 0);
        reset = 1'b0;
        ta = 0;
        tb_t = 0;
        $display("reset clk_1Hz=%0d A=%04d B=%04d", level_1hz, disp_a(), disp_b());
    endtask

    initial begin
        reset = 1'b1; clk_1Hz = 1'b0; run = 1'b0; clear = 1'b0; down = 1'b0;
        do_reset(1'b0);

        // Basic count from 00:00.
        run = 1'b1; down = 1'b0;
        idle(90, "pre");
        one_tick(1'b1, 1'b0);

        // Pause: ticks keep pulsing, digits frozen, and no stored tick.
        run = 1'b0;
        for (int i = 0; i < 5; i++) one_tick(1'b1, 1'b0);
        run = 1'b1;
        idle(10, "resume");

        // Up-wrap: 3599 ticks reach 59:59 (and 09:59 on the MAX_MIN=9 counter).
        clear_pulse();
        for (int i = 0; i < 3599; i++) one_tick(1'b0, 1'b0);
        chk("pre_wrap_a", disp_a(), 5959);
        chk("pre_wrap_b", disp_b(), 959);
        one_tick(1'b1, 1'b0);

        // Down-wrap from 00:00.
        clear_pulse();
        down = 1'b1;
        one_tick(1'b1, 1'b0);

        // Borrow from 01:00 down to 00:59 without a rollover.
        clear_pulse();
        down = 1'b0;
        for (int i = 0; i < 60; i++) one_tick(1'b0, 1'b0);
        down = 1'b1;
        one_tick(1'b1, 1'b0);

        // Random run/down mix, with occasional clear on a tick.
        for (int i = 0; i < 40; i++) begin
            run  = 1'($urandom_range(3, 0) != 0);
            down = 1'($urandom_range(1, 0));
            one_tick(1'b1, 1'($urandom_range(7, 0) == 0));
        end

        // Clear coinciding with a counting tick.
        run = 1'b1; down = 1'b0;
        one_tick(1'b0, 1'b0);
        one_tick(1'b1, 1'b1);

        // clk_1Hz high through reset release: not an edge until it goes low then high.
        do_reset(1'b1);
        idle(15, "held_high");
        clk_1Hz = 1'b0;
        idle(6, "low_after_rst");
        one_tick(1'b1, 1'b0);

        // Reset mid-flight: an edge already in the synchronizer is dropped.
        @(negedge clk);
        clk_1Hz = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        clk_1Hz = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ta = 0;
        tb_t = 0;
        idle(10, "inflight");
        one_tick(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seconds_minutes_counter.md
SECONDS_MINUTES_COUNTER -- requirements
Module: seconds_minutes_counter

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, giving the highest minutes value (legal range 1..59).
REQ-002 SHALL have port clk, input, 1 bit: 50 MHz system clock; the only clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port clk_1Hz, input, 1 bit: slow square wave from the 1 Hz generator, treated as data and never used as a clock.
REQ-005 SHALL have port run, input, 1 bit: counting enabled while high.
REQ-006 SHALL have port clear, input, 1 bit: synchronous clear of the time to 00:00.
REQ-007 SHALL have port down, input, 1 bit: 0 counts up, 1 counts down.
REQ-008 SHALL have port sec_ones, output, 4 bits: BCD 0..9.
REQ-009 SHALL have port sec_tens, output, 3 bits: 0..5.
REQ-010 SHALL have port min_ones, output, 4 bits: BCD 0..9.
REQ-011 SHALL have port min_tens, output, 3 bits: 0..5.
REQ-012 SHALL have port tick, output, 1 bit: one-clk pulse per accepted clk_1Hz rising edge.
REQ-013 SHALL have port rollover, output, 1 bit: one-clk pulse on wrap.

Function
REQ-014 SHALL pass clk_1Hz through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-015 SHALL detect a rising edge when s2=1 and s3=0, but only while armed.
REQ-016 SHALL set armed when s2=0 is first observed after reset, and SHALL leave it set until the next reset.
REQ-017 SHALL consequently ignore a clk_1Hz that is already high at reset release, not counting it as an edge.
REQ-018 SHALL register tick: tick is high for exactly one cycle, the 3rd clk rising edge after the edge at which s1 first samples clk_1Hz=1.
REQ-019 SHALL drive tick regardless of run.
REQ-020 SHALL update the digits on the clk edge at which tick is high, provided run=1; the new value is visible in the cycle after tick.
REQ-021 SHALL leave the digits unchanged on a tick with run=0, and SHALL NOT store that tick for later.
REQ-022 SHALL keep the edge detector running while run=0, so raising run never creates a spurious tick.
REQ-023 SHALL count up (down=0) as BCD seconds 00..59 with carry into minutes 00..MAX_MIN.
REQ-024 SHALL wrap the up-count from MAX_MIN:59 to 00:00 and pulse rollover for one cycle in that same update cycle.
REQ-025 SHALL count down (down=1) with borrow, wrapping 00:00 to MAX_MIN:59 with a one-cycle rollover pulse.
REQ-026 SHALL sample down only at the update edge; a change of down between ticks takes effect on the next tick.
REQ-027 SHALL give clear priority over a same-cycle counting tick: the result is 00:00, rollover=0, and tick still pulses.
REQ-028 SHALL make each digit field's next value a legal BCD value, never exceeding 9, or 5 for tens digits.

Reset
REQ-029 SHALL, with reset high, set all digits, tick, rollover, s1, s2, s3 and armed to 0 at the next clk edge.
REQ-030 SHALL give reset priority over clear, tick and run.
REQ-031 SHALL, on reset asserted mid-count, abandon any pending synchronizer edge; no tick is produced from an edge in flight.

Verification
REQ-032 Bench SHALL cover basic count: run=1, down=0, a clk_1Hz rise at cycle 100 -> tick high at cycle 103 only, display 00:01 from cycle 104.
REQ-033 Bench SHALL cover up-wrap: preload via 3599 ticks to 59:59, then 1 tick -> 00:00, rollover high for 1 cycle, coincident with the digit update.
REQ-034 Bench SHALL cover down-wrap and borrow: clear, down=1, 1 tick -> 59:59 with rollover; from 01:00, 1 tick -> 00:59, rollover=0.
REQ-035 Bench SHALL cover pause: run=0 across 5 ticks -> tick pulses 5 times and the digits are frozen; run=1 with no edge -> no change.
REQ-036 Bench SHALL cover reset corners: clk_1Hz held high through reset release -> no tick until a low-then-high occurs; clear coinciding with a tick -> 00:00 with rollover=0.
REQ-037 Bench SHALL cover the parameter: MAX_MIN=9 at 09:59 up, 1 tick -> 00:00 with rollover.
